// File: rtl/fpu_addsub.sv
// fpu_addsub: multi-cycle floating-point adder/subtractor with round-to-nearest-even.
// One operation is in flight at a time. Results appear 5 clocks after start is accepted.
module fpu_addsub #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic [EXP_W+FRAC_W:0] Op_A_in,
  input  logic [EXP_W+FRAC_W:0] Op_B_in,
  output logic                  busy,
  output logic                  done,
  output logic [EXP_W+FRAC_W:0] data_out,
  output logic [3:0]            status_out
);
  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int M   = FRAC_W + 1;                    // mantissa incl. hidden bit
  localparam int XW  = M + 3;                         // mantissa + guard/round/sticky
  localparam int SW  = XW + 1;                        // sum incl. carry
  localparam int EW  = EXP_W + 2 + $clog2(FRAC_W + 4); // signed exponent headroom
  localparam int LZW = $clog2(XW + 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;

  function automatic logic [LZW-1:0] lzc(input logic [XW-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = XW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + LZW'(1);
      end
    end
    return n;
  endfunction

  function automatic logic rne_inc(input logic lsb, input logic g, input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

  state_t state_q, state_d;
  logic   done_q;
  logic [W-1:0] data_q;
  logic [3:0]   status_q;

  // Captured request
  logic [W-1:0] a_q, b_q;
  logic         sub_q;
  // UNPACK results
  logic             sa_q, sb_q, negz_q, spec_q;
  logic [EXP_W-1:0] ea_q, eb_q;
  logic [M-1:0]     ma_q, mb_q;
  logic [W-1:0]     spec_res_q;
  logic [3:0]       spec_st_q;
  // ALIGN results
  logic             sgn_q, eff_sub_q;
  logic [EXP_W-1:0] exp_q;
  logic [XW-1:0]    ext_l_q, ext_s_q;
  // ADD result
  logic [SW-1:0]    sum_q;
  // NORM results
  logic [XW-1:0]        norm_q;
  logic signed [EW-1:0] nexp_q;
  logic                 nzero_q;

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign data_out   = data_q;
  assign status_out = status_q;

  // Next-state sequencing: every non-idle state lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_UNPACK;
      S_UNPACK: state_d = S_ALIGN;
      S_ALIGN:  state_d = S_ADD;
      S_ADD:    state_d = S_NORM;
      S_NORM:   state_d = S_ROUND;
      S_ROUND:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // UNPACK: field extraction, zero flush, special-operand result
  logic             up_sa, up_sb, up_za, up_zb, up_ia, up_ib;
  logic [EXP_W-1:0] up_ea, up_eb;
  logic [M-1:0]     up_ma, up_mb;
  logic [W-1:0]     up_spec_res;
  logic [3:0]       up_spec_st;
  always_comb begin
    up_sa       = a_q[W-1];
    up_sb       = b_q[W-1] ^ sub_q;
    up_ea       = a_q[W-2:FRAC_W];
    up_eb       = b_q[W-2:FRAC_W];
    up_za       = (up_ea == '0);
    up_zb       = (up_eb == '0);
    up_ia       = &up_ea;
    up_ib       = &up_eb;
    up_ma       = up_za ? '0 : {1'b1, a_q[FRAC_W-1:0]};
    up_mb       = up_zb ? '0 : {1'b1, b_q[FRAC_W-1:0]};
    up_spec_st  = 4'b1000;
    up_spec_res = {up_sb, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    if (up_ia && up_ib && (up_sa != up_sb)) begin
      up_spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
      up_spec_st  = 4'b0000;
    end else if (up_ia) begin
      up_spec_res = {up_sa, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end
  end

  // ALIGN: larger magnitude first, smaller shifted right with G/R/S
  logic             al_a_big, al_sl, al_ss;
  logic [EXP_W-1:0] al_el, al_es, al_diff;
  logic [M-1:0]     al_ml, al_ms;
  logic [2*M+3:0]   al_wide;
  logic [XW-1:0]    al_ext_s;
  always_comb begin
    al_a_big = ({ea_q, ma_q} >= {eb_q, mb_q});
    al_sl    = al_a_big ? sa_q : sb_q;
    al_ss    = al_a_big ? sb_q : sa_q;
    al_el    = al_a_big ? ea_q : eb_q;
    al_es    = al_a_big ? eb_q : ea_q;
    al_ml    = al_a_big ? ma_q : mb_q;
    al_ms    = al_a_big ? mb_q : ma_q;
    al_diff  = al_el - al_es;
    al_wide  = {al_ms, 2'b00, {(M+2){1'b0}}} >> al_diff;
    if (int'(al_diff) >= M + 2) al_ext_s = {{(XW-1){1'b0}}, |al_ms};
    else                        al_ext_s = {al_wide[2*M+3:M+2], |al_wide[M+1:0]};
  end

  // NORM: carry shifts right, otherwise left by leading-zero count
  logic [LZW-1:0]       nm_lz;
  logic signed [EW-1:0] nm_exp_x, nm_exp;
  logic [XW-1:0]        nm_norm;
  always_comb begin
    nm_lz    = lzc(sum_q[XW-1:0]);
    nm_exp_x = $signed({{(EW-EXP_W){1'b0}}, exp_q});
    if (sum_q[SW-1]) begin
      nm_norm = {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
      nm_exp  = nm_exp_x + EW'(1);
    end else begin
      nm_norm = sum_q[XW-1:0] << nm_lz;
      nm_exp  = nm_exp_x - $signed({{(EW-LZW){1'b0}}, nm_lz});
    end
  end

  // ROUND: RNE increment, then overflow / underflow / zero / special selection
  logic [M:0]           rd_mant;
  logic signed [EW-1:0] rd_exp;
  logic                 rd_inx;
  logic [W-1:0]         rd_res;
  logic [3:0]           rd_st;
  logic                 unused_hidden;
  always_comb begin
    rd_inx  = norm_q[2] | norm_q[1] | norm_q[0];
    rd_mant = {1'b0, norm_q[XW-1:3]} +
              {{M{1'b0}}, rne_inc(norm_q[3], norm_q[2], norm_q[1], norm_q[0])};
    rd_exp  = nexp_q + $signed({{(EW-1){1'b0}}, rd_mant[M]});
    unused_hidden = rd_mant[FRAC_W];
    rd_res  = {sgn_q, rd_exp[EXP_W-1:0], rd_mant[FRAC_W-1:0]};
    rd_st   = {~rd_inx, 2'b00, rd_inx};
    if (spec_q) begin
      rd_res = spec_res_q;
      rd_st  = spec_st_q;
    end else if (nzero_q) begin
      rd_res = {negz_q, {(W-1){1'b0}}};
      rd_st  = 4'b1000;
    end else if (!rd_exp[EW-1] && (rd_exp >= EMAX)) begin
      rd_res = {sgn_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      rd_st  = 4'b0101;
    end else if (rd_exp[EW-1] || (rd_exp == '0)) begin
      rd_res = {sgn_q, {(W-1){1'b0}}};
      rd_st  = 4'b0011;
    end
  end

  // Control and visible outputs; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      data_q   <= '0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_ROUND);
      if (state_q == S_ROUND) begin
        data_q   <= rd_res;
        status_q <= rd_st;
      end
    end
  end

  // Datapath stage registers, each loaded only in its own state
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      a_q   <= Op_A_in;
      b_q   <= Op_B_in;
      sub_q <= op_sub;
    end
    if (state_q == S_UNPACK) begin
      sa_q       <= up_sa;
      sb_q       <= up_sb;
      ea_q       <= up_ea;
      eb_q       <= up_eb;
      ma_q       <= up_ma;
      mb_q       <= up_mb;
      negz_q     <= up_za & up_zb & up_sa & up_sb;
      spec_q     <= up_ia | up_ib;
      spec_res_q <= up_spec_res;
      spec_st_q  <= up_spec_st;
    end
    if (state_q == S_ALIGN) begin
      sgn_q     <= al_sl;
      eff_sub_q <= al_sl ^ al_ss;
      exp_q     <= al_el;
      ext_l_q   <= {al_ml, 3'b000};
      ext_s_q   <= al_ext_s;
    end
    if (state_q == S_ADD) begin
      sum_q <= eff_sub_q ? ({1'b0, ext_l_q} - {1'b0, ext_s_q})
                         : ({1'b0, ext_l_q} + {1'b0, ext_s_q});
    end
    if (state_q == S_NORM) begin
      norm_q  <= nm_norm;
      nexp_q  <= nm_exp;
      nzero_q <= (sum_q == '0);
    end
  end

endmodule

// File: tb/tb_fpu_addsub.sv
// Directed testbench for fpu_addsub: single precision plus a half-precision instance.
module tb_fpu_addsub;
  logic        clk, rst_n;
  logic        start, op_sub;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  logic        h_start, h_sub;
  logic [15:0] h_a, h_b;
  logic        h_busy, h_done;
  logic [15:0] h_data;
  logic [3:0]  h_status;

  int n_chk  = 0;
  int n_fail = 0;

  fpu_addsub u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
    .Op_A_in(op_a), .Op_B_in(op_b), .busy(busy), .done(done),
    .data_out(data_out), .status_out(status_out)
  );

  fpu_addsub #(.EXP_W(5), .FRAC_W(10)) u_half (
    .clk(clk), .rst_n(rst_n), .start(h_start), .op_sub(h_sub),
    .Op_A_in(h_a), .Op_B_in(h_b), .busy(h_busy), .done(h_done),
    .data_out(h_data), .status_out(h_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for done; lat = edges after acceptance
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output logic [31:0] res, output logic [3:0] st, output int lat);
    int i;
    lat = -1; res = '0; st = '0; i = 0;
    @(negedge clk);
    op_a = a; op_b = b; op_sub = sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (lat < 0 && i < 20) begin
      i++;
      @(posedge clk); #1;
      if (done) begin lat = i; res = data_out; st = status_out; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got busy=%b done=%b, expected 0 0", busy, done);
    end
    n_chk++;
    if (data_out !== 32'h0 || status_out !== 4'h0) begin
      n_fail++; $display("FAIL reset_data: got %h/%b, expected 00000000/0000", data_out, status_out);
    end
    n_chk++;
    if (h_busy !== 1'b0 || h_done !== 1'b0 || h_data !== 16'h0 || h_status !== 4'h0) begin
      n_fail++; $display("FAIL reset_half: got %b %b %h %b, expected all zero", h_busy, h_done, h_data, h_status);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic eb, ed;
    @(negedge clk);
    op_a = 32'h3F800000; op_b = 32'h3F800000; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      eb = (i < 5);
      ed = (i == 5);
      n_chk++;
      if (busy !== eb || done !== ed) begin
        n_fail++; $display("FAIL basic_handshake edge N+%0d: got busy=%b done=%b, expected %b %b", i, busy, done, eb, ed);
      end
      if (i == 5) begin
        n_chk++;
        if (data_out !== 32'h40000000 || status_out !== 4'b1000) begin
          n_fail++; $display("FAIL basic_result: got %h/%b, expected 40000000/1000", data_out, status_out);
        end
      end
    end
    n_chk++;
    if (data_out !== 32'h40000000 || status_out !== 4'b1000) begin
      n_fail++; $display("FAIL basic_hold: got %h/%b, expected 40000000/1000", data_out, status_out);
    end
  endtask

  task automatic test_rne();
    logic [31:0] va [3], vb [3], vr [3];
    logic [3:0]  vs [3];
    logic [31:0] res; logic [3:0] st; int lat;
    va = '{32'h3F800000, 32'h3F800001, 32'h3F800000};
    vb = '{32'h33800000, 32'h33800000, 32'h33800001};
    vr = '{32'h3F800000, 32'h3F800002, 32'h3F800001};
    vs = '{4'b0001, 4'b0001, 4'b0001};
    for (int k = 0; k < 3; k++) begin
      run_op(va[k], vb[k], 1'b0, res, st, lat);
      n_chk++;
      if (lat !== 5) begin
        n_fail++; $display("FAIL rne_latency[%0d]: got %0d, expected 5", k, lat);
      end
      n_chk++;
      if (res !== vr[k] || st !== vs[k]) begin
        n_fail++; $display("FAIL rne[%0d]: got %h/%b, expected %h/%b", k, res, st, vr[k], vs[k]);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] va [6], vb [6], vr [6];
    logic        vsub [6];
    logic [3:0]  vs [6];
    logic [31:0] res; logic [3:0] st; int lat;
    va   = '{32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h80000000, 32'h00000000, 32'h7F800000};
    vb   = '{32'h7F7FFFFF, 32'h7F800000, 32'hFF800000, 32'h80000000, 32'hC0400000, 32'h7F800000};
    vsub = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vr   = '{32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'hC0400000, 32'h7F800000};
    vs   = '{4'b0101, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
    for (int k = 0; k < 6; k++) begin
      run_op(va[k], vb[k], vsub[k], res, st, lat);
      n_chk++;
      if (lat !== 5 || res !== vr[k] || st !== vs[k]) begin
        n_fail++; $display("FAIL special[%0d]: got %h/%b lat %0d, expected %h/%b lat 5", k, res, st, lat, vr[k], vs[k]);
      end
    end
  endtask

  task automatic test_cancel();
    logic [31:0] va [5], vb [5], vr [5];
    logic [3:0]  vs [5];
    logic [31:0] res; logic [3:0] st; int lat;
    va = '{32'h3F800000, 32'h00C00000, 32'h3F800001, 32'h40000000, 32'h3F800000};
    vb = '{32'h3F800000, 32'h00800000, 32'h3F800000, 32'h3F800000, 32'h40000000};
    vr = '{32'h00000000, 32'h00000000, 32'h34000000, 32'h3F800000, 32'hBF800000};
    vs = '{4'b1000, 4'b0011, 4'b1000, 4'b1000, 4'b1000};
    for (int k = 0; k < 5; k++) begin
      run_op(va[k], vb[k], 1'b1, res, st, lat);
      n_chk++;
      if (lat !== 5 || res !== vr[k] || st !== vs[k]) begin
        n_fail++; $display("FAIL cancel[%0d]: got %h/%b lat %0d, expected %h/%b lat 5", k, res, st, lat, vr[k], vs[k]);
      end
    end
  endtask

  task automatic test_handshake();
    int cnt, first;
    logic [31:0] r1, res; logic [3:0] st; int lat;
    // A second start pulse mid-operation must be ignored
    cnt = 0; first = -1; r1 = '0;
    @(negedge clk);
    op_a = 32'h3F800000; op_b = 32'h3F800000; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin op_a = 32'h40400000; op_b = 32'h40400000; start = 1'b1; end
      if (i == 2) start = 1'b0;
      if (done) begin
        cnt++;
        if (first < 0) begin first = i; r1 = data_out; end
      end
    end
    n_chk++;
    if (cnt !== 1 || first !== 5) begin
      n_fail++; $display("FAIL ignore_start: got %0d done pulses first at N+%0d, expected 1 at N+5", cnt, first);
    end
    n_chk++;
    if (r1 !== 32'h40000000) begin
      n_fail++; $display("FAIL ignore_start_result: got %h, expected 40000000", r1);
    end
    // Asynchronous reset mid-operation clears outputs, no done follows
    @(negedge clk);
    op_a = 32'h3F800000; op_b = 32'h33800001; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || data_out !== 32'h0 || status_out !== 4'h0) begin
      n_fail++; $display("FAIL midop_reset: got busy=%b done=%b %h/%b, expected 0 0 00000000/0000", busy, done, data_out, status_out);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) cnt++;
    end
    n_chk++;
    if (cnt !== 0) begin
      n_fail++; $display("FAIL reset_discard: got %0d active cycles, expected 0", cnt);
    end
    run_op(32'h3F800000, 32'h33800001, 1'b0, res, st, lat);
    n_chk++;
    if (lat !== 5 || res !== 32'h3F800001 || st !== 4'b0001) begin
      n_fail++; $display("FAIL after_reset: got %h/%b lat %0d, expected 3F800001/0001 lat 5", res, st, lat);
    end
  endtask

  task automatic test_back_to_back();
    int cnt, e1, e2;
    logic [31:0] r1, r2; logic [3:0] s2;
    cnt = 0; e1 = -1; e2 = -1; r1 = '0; r2 = '0; s2 = '0;
    @(negedge clk);
    op_a = 32'h3F800000; op_b = 32'h3F800000; op_sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    op_a = 32'h40000000; op_b = 32'h3F800000;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      if (i == 6) start = 1'b0;
      if (done) begin
        cnt++;
        if (e1 < 0) begin e1 = i; r1 = data_out; end
        else begin e2 = i; r2 = data_out; s2 = status_out; end
      end
    end
    n_chk++;
    if (cnt !== 2 || e1 !== 5 || e2 !== 11) begin
      n_fail++; $display("FAIL b2b_timing: got %0d dones at N+%0d, N+%0d, expected 2 at N+5, N+11", cnt, e1, e2);
    end
    n_chk++;
    if (r1 !== 32'h00000000 || r2 !== 32'h3F800000 || s2 !== 4'b1000) begin
      n_fail++; $display("FAIL b2b_results: got %h, %h/%b, expected 00000000, 3F800000/1000", r1, r2, s2);
    end
  endtask

  task automatic test_half();
    logic [15:0] va [3], vb [3], vr [3];
    logic        vsub [3];
    logic [3:0]  vs [3];
    logic [15:0] res; logic [3:0] st; int lat, i;
    va   = '{16'h3C00, 16'h7BFF, 16'h4000};
    vb   = '{16'h3C00, 16'h7BFF, 16'h3C00};
    vsub = '{1'b0, 1'b0, 1'b1};
    vr   = '{16'h4000, 16'h7C00, 16'h3C00};
    vs   = '{4'b1000, 4'b0101, 4'b1000};
    for (int k = 0; k < 3; k++) begin
      lat = -1; res = '0; st = '0; i = 0;
      @(negedge clk);
      h_a = va[k]; h_b = vb[k]; h_sub = vsub[k]; h_start = 1'b1;
      @(posedge clk); #1;
      h_start = 1'b0;
      while (lat < 0 && i < 20) begin
        i++;
        @(posedge clk); #1;
        if (h_done) begin lat = i; res = h_data; st = h_status; end
      end
      n_chk++;
      if (lat !== 5 || res !== vr[k] || st !== vs[k]) begin
        n_fail++; $display("FAIL half[%0d]: got %h/%b lat %0d, expected %h/%b lat 5", k, res, st, lat, vr[k], vs[k]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; op_a = '0; op_b = '0;
    h_start = 1'b0; h_sub = 1'b0; h_a = '0; h_b = '0;
    test_reset();
    test_basic();
    test_rne();
    test_special();
    test_cancel();
    test_handshake();
    test_back_to_back();
    test_half();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
